// File: rtl/ttc_trigger_receiver_mc_if.sv
// Handshake bundle between the trigger receiver, the acquisition controller and the TTC trigger FIFO.
interface ttc_trigger_receiver_mc_if;
  logic         acq_trigger;
  logic [4:0]   acq_trig_type;
  logic [23:0]  acq_trig_num;
  logic         acq_ready;
  logic         fifo_valid;
  logic         fifo_ready;
  logic [127:0] fifo_data;

  modport master (
    output acq_trigger, acq_trig_type, acq_trig_num, fifo_valid, fifo_data,
    input  acq_ready, fifo_ready
  );

  modport slave (
    input  acq_trigger, acq_trig_type, acq_trig_num, fifo_valid, fifo_data,
    output acq_ready, fifo_ready
  );
endinterface

// File: rtl/ttc_trigger_receiver_mc.sv
// Multi-channel TTC trigger receiver: gates L1A triggers on type, mode and DDR3 occupancy,
// forwards accepted ones to acquisition and writes one 128-bit record per trigger.
module ttc_trigger_receiver_mc #(
  parameter int         NCHAN      = 5,
  parameter int         BURST_W    = 23,
  parameter logic [4:0] ASYNC_TYPE = 5'd7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       reset_trig_num,
  input  logic                       reset_trig_timestamp,
  input  logic                       trigger,
  input  logic [4:0]                 trig_type,
  input  logic [31:0]                trig_settings,
  input  logic                       async_mode,
  input  logic                       busy_mode,
  input  logic [NCHAN-1:0]           chan_en,
  input  logic [NCHAN*BURST_W-1:0]   acq_size,
  input  logic [BURST_W-1:0]         thres_ddr3_overflow,
  input  logic                       readout_done,
  input  logic [BURST_W-1:0]         readout_size,
  ttc_trigger_receiver_mc_if.master  bus,
  output logic [3:0]                 state,
  output logic [23:0]                trig_num,
  output logic [43:0]                trig_timestamp,
  output logic [31:0]                ddr3_overflow_count,
  output logic [31:0]                busy_drop_count,
  output logic [NCHAN-1:0]           ddr3_overflow_warning,
  output logic                       error_underflow,
  output logic                       error_trig_rate
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_SEND  = 4'b0010,
    S_STORE = 4'b0100,
    S_ERROR = 4'b1000
  } state_t;

  localparam logic [BURST_W:0] CAPACITY = {1'b1, {BURST_W{1'b0}}};

  state_t        state_reg;
  logic [43:0]   ts_reg, trig_ts_reg;
  logic [23:0]   trig_num_reg, acq_num_reg, event_reg;
  logic [4:0]    acq_type_reg;
  logic          empty_reg, fifo_valid_reg, underflow_reg;
  logic [127:0]  fifo_data_reg;
  logic [31:0]   ovf_cnt_reg, drop_cnt_reg;

  logic [NCHAN-1:0] chan_full, chan_under;
  logic ddr3_full, type_ok_in, type_ok_lat, acq_fire;
  logic send_drop, busy_trig, ovf_inc;
  logic [1:0] drop_inc;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {31'd0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

  assign ddr3_full   = |chan_full;
  assign type_ok_in  = async_mode ? (trig_type == ASYNC_TYPE) : trig_settings[trig_type];
  assign type_ok_lat = async_mode ? (acq_type_reg == ASYNC_TYPE) : trig_settings[acq_type_reg];
  // Fullness is re-evaluated in SEND so a readout landing between IDLE and SEND is honoured.
  assign acq_fire  = (state_reg == S_SEND) && bus.acq_ready && type_ok_lat && !(!async_mode && ddr3_full);
  assign send_drop = (state_reg == S_SEND) && !bus.acq_ready && busy_mode;
  assign busy_trig = ((state_reg == S_SEND) || (state_reg == S_STORE)) && trigger && busy_mode;
  assign ovf_inc   = (state_reg == S_SEND) && bus.acq_ready && type_ok_lat && !async_mode && ddr3_full;
  assign drop_inc  = {1'b0, send_drop} + {1'b0, busy_trig};

  for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
    logic [BURST_W:0]   stored_reg;
    logic [BURST_W:0]   size_ext, diff;
    logic [BURST_W+1:0] plus, minus;

    assign size_ext = {1'b0, acq_size[gi*BURST_W +: BURST_W]};
    assign plus     = {1'b0, stored_reg} + ((acq_fire && chan_en[gi]) ? {1'b0, size_ext} : '0);
    assign minus    = (readout_done && chan_en[gi]) ? {2'b00, readout_size} : '0;
    assign diff     = plus[BURST_W:0] - minus[BURST_W:0];
    assign chan_under[gi] = plus < minus;
    assign chan_full[gi]  = chan_en[gi] && ((CAPACITY - stored_reg) < size_ext);
    assign ddr3_overflow_warning[gi] = stored_reg > {1'b0, thres_ddr3_overflow};

    always_ff @(posedge clk) begin
      if (reset || async_mode || chan_under[gi]) stored_reg <= '0;
      else                                       stored_reg <= diff;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      ts_reg         <= '0;
      trig_ts_reg    <= '0;
      trig_num_reg   <= 24'd1;
      acq_num_reg    <= 24'd1;
      event_reg      <= 24'd1;
      acq_type_reg   <= '0;
      empty_reg      <= 1'b0;
      fifo_valid_reg <= 1'b0;
      fifo_data_reg  <= '0;
      ovf_cnt_reg    <= '0;
      drop_cnt_reg   <= '0;
      underflow_reg  <= 1'b0;
    end else begin
      ts_reg       <= ts_reg + 44'd1;
      drop_cnt_reg <= sat_add(drop_cnt_reg, drop_inc);
      ovf_cnt_reg  <= sat_add(ovf_cnt_reg, {1'b0, ovf_inc});
      if (!async_mode && |chan_under) underflow_reg <= 1'b1;
      if (busy_trig) trig_num_reg <= trig_num_reg + 24'd1;

      case (state_reg)
        S_IDLE: begin
          if (trigger) begin
            acq_num_reg  <= trig_num_reg;
            trig_num_reg <= trig_num_reg + 24'd1;
            acq_type_reg <= trig_type;
            trig_ts_reg  <= ts_reg;
            empty_reg    <= !type_ok_in || (!async_mode && ddr3_full);
            state_reg    <= S_SEND;
          end
        end
        S_SEND: begin
          fifo_data_reg <= {30'd0, !acq_fire, acq_type_reg, event_reg, acq_num_reg, trig_ts_reg};
          empty_reg     <= !acq_fire;
          if (acq_fire) event_reg <= event_reg + 24'd1;
          if ((!bus.acq_ready || trigger) && !busy_mode) begin
            state_reg <= S_ERROR;
          end else begin
            state_reg      <= S_STORE;
            fifo_valid_reg <= 1'b1;
          end
        end
        S_STORE: begin
          if (trigger && !busy_mode) begin
            state_reg      <= S_ERROR;
            fifo_valid_reg <= 1'b0;
          end else if (fifo_valid_reg && bus.fifo_ready) begin
            state_reg      <= S_IDLE;
            fifo_valid_reg <= 1'b0;
            empty_reg      <= 1'b0;
          end
        end
        default: fifo_valid_reg <= 1'b0;
      endcase

      // Chan-B resets win over whatever the FSM did to the same registers this cycle.
      if (reset_trig_num) begin
        trig_num_reg <= 24'd1;
        acq_num_reg  <= 24'd1;
        event_reg    <= 24'd1;
      end
      if (reset_trig_timestamp) begin
        ts_reg      <= '0;
        trig_ts_reg <= '0;
      end
    end
  end

  assign bus.acq_trigger   = acq_fire;
  assign bus.acq_trig_type = acq_type_reg;
  assign bus.acq_trig_num  = acq_num_reg;
  assign bus.fifo_valid    = fifo_valid_reg;
  assign bus.fifo_data     = fifo_data_reg;
  assign state               = state_reg;
  assign trig_num            = trig_num_reg;
  assign trig_timestamp      = trig_ts_reg;
  assign ddr3_overflow_count = ovf_cnt_reg;
  assign busy_drop_count     = drop_cnt_reg;
  assign error_underflow     = underflow_reg;
  assign error_trig_rate     = (state_reg == S_ERROR);

endmodule
